ctl_setup_rx: RTL and testbench

//  Receive side of USB control transfers. Parses the 8-byte SETUP DATA0

---
 rtl/ctl_setup_rx.sv | 192 +++++++++++++++++++
 tb/tb_ctl_setup_rx.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctl_setup_rx.sv
// Receive side of USB control transfers: parses the 8-byte SETUP payload into
// request fields and tracks the SETUP / DATA / STATUS stages of the control pipe.
module ctl_setup_rx #(
    parameter logic [15:0] ENDPT_MASK = 16'h0001
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        setup_i,
    input  logic        in_tok_i,
    input  logic        out_tok_i,
    input  logic [3:0]  tok_endpt_i,
    input  logic        hsk_ack_i,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic        s_tlast,
    input  logic        s_tuser,
    input  logic [7:0]  s_tdata,
    output logic        select_o,
    output logic        start_o,
    output logic        done_o,
    output logic        error_o,
    output logic [1:0]  stage_o,
    output logic [3:0]  req_endpt_o,
    output logic [7:0]  req_type_o,
    output logic [7:0]  req_args_o,
    output logic [15:0] req_value_o,
    output logic [15:0] req_index_o,
    output logic [15:0] req_length_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_DATA   = 2'd2,
        ST_STATUS = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  shadow_q [7];
    logic [7:0]  shadow_d [7];
    logic [3:0]  shadow_ep_q, shadow_ep_d;
    logic        select_q, select_d;
    logic        start_q, start_d;
    logic        error_q, error_d;
    logic        done_q, done_d;
    logic [3:0]  req_endpt_q, req_endpt_d;
    logic [7:0]  req_type_q, req_type_d;
    logic [7:0]  req_args_q, req_args_d;
    logic [15:0] req_value_q, req_value_d;
    logic [15:0] req_index_q, req_index_d;
    logic [15:0] req_length_q, req_length_d;

    logic        setup_ok;
    logic        beat;
    logic        last_beat;
    logic        good;
    logic        data_done;
    logic [15:0] new_length;

    // Stream handshake: a byte transfers on any cycle with s_tvalid && s_tready;
    // s_tready depends only on the stage, never on s_tvalid.
    assign s_tready   = (state_q == ST_SETUP);
    assign setup_ok   = setup_i && ENDPT_MASK[tok_endpt_i];
    assign beat       = s_tvalid && s_tready;
    assign last_beat  = beat && s_tlast;
    assign good       = last_beat && (cnt_q == 4'd7) && s_tuser && !ovf_q;
    // Byte 7 bypasses the shadow so the request is latched on the tlast edge.
    assign new_length = {s_tdata, shadow_q[6]};
    assign data_done  = (tok_endpt_i == req_endpt_q) &&
                        (req_type_q[7] ? out_tok_i : in_tok_i);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            ovf_q        <= 1'b0;
            shadow_q     <= '{default: 8'd0};
            shadow_ep_q  <= 4'd0;
            select_q     <= 1'b0;
            start_q      <= 1'b0;
            error_q      <= 1'b0;
            done_q       <= 1'b0;
            req_endpt_q  <= 4'd0;
            req_type_q   <= 8'd0;
            req_args_q   <= 8'd0;
            req_value_q  <= 16'd0;
            req_index_q  <= 16'd0;
            req_length_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            shadow_q     <= shadow_d;
            shadow_ep_q  <= shadow_ep_d;
            select_q     <= select_d;
            start_q      <= start_d;
            error_q      <= error_d;
            done_q       <= done_d;
            req_endpt_q  <= req_endpt_d;
            req_type_q   <= req_type_d;
            req_args_q   <= req_args_d;
            req_value_q  <= req_value_d;
            req_index_q  <= req_index_d;
            req_length_q <= req_length_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (setup_ok) begin
            state_d = ST_SETUP;
        end else begin
            case (state_q)
                ST_SETUP: begin
                    if (last_beat) begin
                        if (!good)                    state_d = ST_IDLE;
                        else if (new_length != 16'd0) state_d = ST_DATA;
                        else                          state_d = ST_STATUS;
                    end
                end
                ST_DATA: begin
                    if (data_done) state_d = ST_STATUS;
                end
                ST_STATUS: begin
                    if (hsk_ack_i) state_d = ST_IDLE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        shadow_d     = shadow_q;
        shadow_ep_d  = shadow_ep_q;
        select_d     = select_q;
        start_d      = 1'b0;
        error_d      = 1'b0;
        done_d       = 1'b0;
        req_endpt_d  = req_endpt_q;
        req_type_d   = req_type_q;
        req_args_d   = req_args_q;
        req_value_d  = req_value_q;
        req_index_d  = req_index_q;
        req_length_d = req_length_q;
        if (setup_ok) begin
            // A new SETUP silently aborts whatever transfer was in flight.
            cnt_d       = 4'd0;
            ovf_d       = 1'b0;
            shadow_ep_d = tok_endpt_i;
            select_d    = 1'b0;
        end else if (state_q == ST_SETUP && beat) begin
            if (cnt_q < 4'd8) begin
                if (cnt_q < 4'd7) shadow_d[cnt_q[2:0]] = s_tdata;
                cnt_d = cnt_q + 4'd1;
            end else begin
                ovf_d = 1'b1;
            end
            if (good) begin
                req_endpt_d  = shadow_ep_q;
                req_type_d   = shadow_q[0];
                req_args_d   = shadow_q[1];
                req_value_d  = {shadow_q[3], shadow_q[2]};
                req_index_d  = {shadow_q[5], shadow_q[4]};
                req_length_d = new_length;
                start_d      = 1'b1;
                select_d     = 1'b1;
            end else if (s_tlast) begin
                error_d = 1'b1;
            end
        end else if (state_q == ST_STATUS && hsk_ack_i) begin
            done_d   = 1'b1;
            select_d = 1'b0;
        end
    end

    assign stage_o      = state_q;
    assign select_o     = select_q;
    assign start_o      = start_q;
    assign error_o      = error_q;
    assign done_o       = done_q;
    assign req_endpt_o  = req_endpt_q;
    assign req_type_o   = req_type_q;
    assign req_args_o   = req_args_q;
    assign req_value_o  = req_value_q;
    assign req_index_o  = req_index_q;
    assign req_length_o = req_length_q;

endmodule

// File: tb/tb_ctl_setup_rx.sv
// Bench for ctl_setup_rx: directed control transfers plus random token/payload
// traffic checked against a transaction-level model of the control pipe.
module tb_ctl_setup_rx;

    localparam logic [15:0] MASK = 16'h0001;
    localparam int RW = 68;

    logic        clk;
    logic        reset;
    logic        setup_i, in_tok_i, out_tok_i, hsk_ack_i;
    logic [3:0]  tok_endpt_i;
    logic        s_tvalid, s_tready, s_tlast, s_tuser;
    logic [7:0]  s_tdata;
    logic        select_o, start_o, done_o, error_o;
    logic [1:0]  stage_o;
    logic [3:0]  req_endpt_o;
    logic [7:0]  req_type_o, req_args_o;
    logic [15:0] req_value_o, req_index_o, req_length_o;

    ctl_setup_rx #(.ENDPT_MASK(MASK)) dut (
        .clock(clk), .reset(reset),
        .setup_i(setup_i), .in_tok_i(in_tok_i), .out_tok_i(out_tok_i),
        .tok_endpt_i(tok_endpt_i), .hsk_ack_i(hsk_ack_i),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .s_tuser(s_tuser), .s_tdata(s_tdata),
        .select_o(select_o), .start_o(start_o), .done_o(done_o),
        .error_o(error_o), .stage_o(stage_o), .req_endpt_o(req_endpt_o),
        .req_type_o(req_type_o), .req_args_o(req_args_o),
        .req_value_o(req_value_o), .req_index_o(req_index_o),
        .req_length_o(req_length_o)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_mis = 0;
    logic [RW-1:0] exp_q[$];
    int n_start_seen = 0, n_err_seen = 0, n_done_seen = 0;
    int m_starts = 0, m_errs = 0, m_dones = 0;

    // Transaction-level model of the control pipe
    int            m_stage;
    logic          m_select;
    logic [3:0]    m_setup_ep;
    logic [RW-1:0] m_req;
    logic [7:0]    pay [16];
    logic [15:0]   mask_v;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] dut_req();
        return {req_endpt_o, req_type_o, req_args_o, req_value_o, req_index_o, req_length_o};
    endfunction

    function automatic logic [RW-1:0] pay_req(input logic [3:0] ep);
        return {ep, pay[0], pay[1], pay[3], pay[2], pay[5], pay[4], pay[7], pay[6]};
    endfunction

    // Pulse monitor: request contents on start_o, pulse exclusivity and width
    logic prev_start = 1'b0, prev_err = 1'b0, prev_done = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (start_o) begin
                n_start_seen++;
                if (exp_q.size() == 0) chk("start_unexpected", 1, 0);
                else chk("start_req", dut_req(), exp_q.pop_front());
            end
            if (error_o) n_err_seen++;
            if (done_o) n_done_seen++;
            if ((32'(start_o) + 32'(error_o) + 32'(done_o)) > 1)
                chk("pulse_exclusive", {start_o, error_o, done_o}, 0);
            if ((start_o && prev_start) || (error_o && prev_err) || (done_o && prev_done))
                chk("pulse_width", {start_o, error_o, done_o}, 0);
        end
        prev_start <= start_o;
        prev_err   <= error_o;
        prev_done  <= done_o;
    end

    task automatic check_state(input string tag);
        chk({tag, "_stage"}, stage_o, m_stage);
        chk({tag, "_select"}, select_o, m_select);
        chk({tag, "_tready"}, s_tready, (m_stage == 1));
        chk({tag, "_req"}, dut_req(), m_req);
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_setup(input logic [3:0] ep);
        setup_i = 1'b1;
        tok_endpt_i = ep;
        @(negedge clk);
        setup_i = 1'b0;
        if (mask_v[ep]) begin
            m_stage = 1;
            m_select = 1'b0;
            m_setup_ep = ep;
        end
        check_state("setup");
    endtask

    // Drives n beats from pay[]; tlast on the final beat only when close is set.
    task automatic drive_beats(input int n, input bit close, input logic tuser);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            while (!s_tready && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (!s_tready) begin
                chk("tready_timeout", 0, 1);
                break;
            end
            s_tvalid = 1'b1;
            s_tdata  = pay[i];
            s_tlast  = close && (i == n - 1);
            s_tuser  = (close && (i == n - 1)) ? tuser : 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic send_payload(input int n, input logic tuser);
        bit good;
        good = (n == 8) && tuser;
        if (good) begin
            m_req = pay_req(m_setup_ep);
            exp_q.push_back(m_req);
            m_select = 1'b1;
            m_stage = ({pay[7], pay[6]} != 16'd0) ? 2 : 3;
            m_starts++;
        end else begin
            m_stage = 0;
            m_errs++;
        end
        drive_beats(n, 1'b1, tuser);
        chk("payload_start", start_o, good);
        chk("payload_error", error_o, !good);
        check_state("payload");
    endtask

    task automatic token(input bit is_out, input logic [3:0] ep);
        in_tok_i = !is_out;
        out_tok_i = is_out;
        tok_endpt_i = ep;
        @(negedge clk);
        in_tok_i = 1'b0;
        out_tok_i = 1'b0;
        // IN-direction data ends when the host sends OUT for status, and vice versa
        if (m_stage == 2 && ep == m_req[67:64] && (m_req[63] == is_out)) m_stage = 3;
        check_state("token");
    endtask

    task automatic ack();
        bit exp_done;
        hsk_ack_i = 1'b1;
        @(negedge clk);
        hsk_ack_i = 1'b0;
        exp_done = (m_stage == 3);
        if (exp_done) begin
            m_stage = 0;
            m_select = 1'b0;
            m_dones++;
        end
        chk("ack_done", done_o, exp_done);
        check_state("ack");
    endtask

    task automatic load(input logic [63:0] bytes);
        for (int i = 0; i < 8; i++) pay[i] = bytes[63 - 8*i -: 8];
        for (int i = 8; i < 16; i++) pay[i] = 8'($urandom);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        mask_v = MASK;
        reset = 1'b1;
        setup_i = 1'b0; in_tok_i = 1'b0; out_tok_i = 1'b0; hsk_ack_i = 1'b0;
        tok_endpt_i = 4'd0;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; s_tdata = 8'd0;
        m_stage = 0; m_select = 1'b0; m_setup_ep = 4'd0; m_req = '0;
        repeat (3) @(negedge clk);
        check_state("reset");
        chk("reset_pulses", {start_o, error_o, done_o}, 0);
        reset = 1'b0;
        @(negedge clk);

        // GET_DESCRIPTOR, IN data stage
        do_setup(4'd0);
        load(64'h80_06_00_01_00_00_12_00);
        send_payload(8, 1'b1);
        chk("gd_type", req_type_o, 8'h80);
        chk("gd_value", req_value_o, 16'h0100);
        chk("gd_length", req_length_o, 16'h0012);
        token(1'b1, 4'd0);
        ack();

        // SET_ADDRESS, no data stage
        do_setup(4'd0);
        load(64'h00_05_07_00_00_00_00_00);
        send_payload(8, 1'b1);
        chk("sa_value", req_value_o, 16'h0007);
        token(1'b0, 4'd0);
        ack();

        // Short, long and corrupt payloads
        do_setup(4'd0); load(64'h80_06_00_02_00_00_40_00); send_payload(7, 1'b1);
        do_setup(4'd0); load(64'h80_06_00_02_00_00_40_00); send_payload(9, 1'b1);
        do_setup(4'd0); load(64'h80_06_00_02_00_00_40_00); send_payload(8, 1'b0);

        // Abort during IN data stage; masked endpoint ignored
        do_setup(4'd0); load(64'h80_06_00_03_00_00_20_00); send_payload(8, 1'b1);
        do_setup(4'd2);
        do_setup(4'd0);
        load(64'hC0_33_44_55_66_77_00_00); send_payload(8, 1'b1);
        ack();

        // setup_i on the tlast beat restarts the SETUP stage
        do_setup(4'd0);
        load(64'h00_09_01_00_00_00_00_00);
        drive_beats(7, 1'b0, 1'b0);
        s_tvalid = 1'b1; s_tdata = pay[7]; s_tlast = 1'b1; s_tuser = 1'b1;
        setup_i = 1'b1; tok_endpt_i = 4'd0;
        @(negedge clk);
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; setup_i = 1'b0;
        m_stage = 1; m_select = 1'b0; m_setup_ep = 4'd0;
        chk("race_start", start_o, 1'b0);
        chk("race_error", error_o, 1'b0);
        check_state("race");
        send_payload(8, 1'b1);
        ack();

        // Random traffic
        for (int it = 0; it < 400; it++) begin
            if (m_stage == 1) begin
                int n;
                n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 8;
                for (int i = 0; i < 16; i++) pay[i] = 8'($urandom);
                if ($urandom_range(0, 2) == 0) begin
                    pay[6] = 8'd0;
                    pay[7] = 8'd0;
                end
                send_payload(n, 1'($urandom_range(0, 5) != 0));
            end else begin
                int op;
                op = $urandom_range(0, 9);
                if (op <= 2) do_setup(4'($urandom_range(0, 3)));
                else if (op <= 5) token(1'($urandom_range(0, 1)),
                                        ($urandom_range(0, 3) == 0) ? 4'd1 : 4'd0);
                else if (op <= 8) ack();
                else begin
                    @(negedge clk);
                    check_state("idle");
                end
            end
        end

        // Reset in the middle of a SETUP payload
        do_setup(4'd0);
        load(64'h80_06_00_01_00_00_12_00);
        drive_beats(4, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        m_stage = 0; m_select = 1'b0; m_req = '0;
        check_state("midreset");
        reset = 1'b0;
        @(negedge clk);
        check_state("postreset");

        chk("count_start", n_start_seen, m_starts);
        chk("count_error", n_err_seen, m_errs);
        chk("count_done", n_done_seen, m_dones);
        chk("exp_q_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
